// File: rtl/apb_regfile_slave_pkg.sv
// Shared definitions for the APB register-file slave.
//   - apb_state_e : bus-phase FSM encodings (same values as the APB master)
//   - WCNT_OFS / STATUS_OFS : slot offsets counted down from NUM_REGS
//                             (slot index = NUM_REGS - *_OFS)
//   - STAT_*_BIT : bit positions inside the STATUS register
package apb_regfile_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd1,
        ST_SETUP  = 2'd3,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned WCNT_OFS      = 2;
    localparam int unsigned STATUS_OFS    = 1;

    localparam int unsigned STAT_PERR_BIT = 0;
    localparam int unsigned STAT_OOR_BIT  = 1;

endpackage

// File: rtl/apb_regfile_slave_phase_tracker.sv
// APB phase tracker: follows IDLE/SETUP/ACCESS, captures the setup-phase
// address/direction/data and checks they stay stable into the access phase.
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_psel/i_penable/i_pwrite    APB control
//   i_paddr, i_pwdata            APB address / write data
//   o_setup_edge                 this edge is a legal setup edge
//   o_access_edge                this edge completes a transfer
//   o_err                        protocol violation on this edge
//   o_addr/o_write/o_wdata       values captured on the last setup edge
module apb_phase_tracker
    import apb_regfile_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic                  o_setup_edge,
    output logic                  o_access_edge,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    apb_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_setup_ph;
    logic w_access_ph;
    logic w_unstable;

    always_comb begin
        w_setup_ph    = i_psel & ~i_penable;
        w_access_ph   = i_psel & i_penable;
        // A setup seen while already in SETUP is an error, not a new setup.
        o_setup_edge  = w_setup_ph && (r_state != ST_SETUP);
        o_access_edge = w_access_ph && (r_state == ST_SETUP);
        w_unstable    = o_access_edge &&
                        ((i_paddr != r_addr) || (i_pwrite != r_write) ||
                         (i_pwdata != r_wdata));
        o_err = w_unstable;
        case (r_state)
            ST_IDLE:   if (w_access_ph)  o_err = 1'b1;
            ST_SETUP:  if (!w_access_ph) o_err = 1'b1;
            ST_ACCESS: if (w_access_ph)  o_err = 1'b1;
            default:   o_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            if (o_setup_edge) begin
                r_addr  <= i_paddr;
                r_write <= i_pwrite;
                r_wdata <= i_pwdata;
            end
            case (r_state)
                ST_IDLE:   r_state <= w_setup_ph ? ST_SETUP : ST_IDLE;
                ST_SETUP:  r_state <= w_access_ph ? ST_ACCESS :
                                      (w_setup_ph ? ST_SETUP : ST_IDLE);
                ST_ACCESS: r_state <= w_setup_ph ? ST_SETUP : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_addr  = r_addr;
    assign o_write = r_write;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB2 zero-wait-state register-file slave.
// Slots 0..NUM_REGS-3 are read/write, NUM_REGS-2 is a read-only write
// counter (WCNT), NUM_REGS-1 is a W1C sticky STATUS register.
// Ports:
//   pclk, reset                       clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata                            registered read data (loaded at setup)
//   regs_flat                         all register slots, slot i at [i*DW +: DW]
//   wr_strobe                         one-hot 1-cycle pulse for the slot written
//   prot_err                          1-cycle pulse per protocol violation
module apb_regfile_slave
    import apb_regfile_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                           pclk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic                           prot_err
);

    localparam int unsigned           IDX_W    = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]      WCNT_IDX = IDX_W'(NUM_REGS - WCNT_OFS);
    localparam logic [IDX_W-1:0]      STAT_IDX = IDX_W'(NUM_REGS - STATUS_OFS);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [NUM_REGS-1:0]   r_wr_strobe;
    logic                  r_prot_err;

    logic                  w_setup_edge;
    logic                  w_access_edge;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_cap_addr;
    logic                  w_cap_write;
    logic [DATA_WIDTH-1:0] w_cap_wdata;

    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_stat_next;

    apb_phase_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_phase (
        .i_clk         (pclk),
        .i_reset       (reset),
        .i_psel        (psel),
        .i_penable     (penable),
        .i_pwrite      (pwrite),
        .i_paddr       (paddr),
        .i_pwdata      (pwdata),
        .o_setup_edge  (w_setup_edge),
        .o_access_edge (w_access_edge),
        .o_err         (w_err),
        .o_addr        (w_cap_addr),
        .o_write       (w_cap_write),
        .o_wdata       (w_cap_wdata)
    );

    always_comb begin
        w_rd_idx      = paddr[IDX_W-1:0];
        w_wr_idx      = w_cap_addr[IDX_W-1:0];
        w_rd_in_range = (paddr[ADDR_WIDTH-1:IDX_W] == BASE_A[ADDR_WIDTH-1:IDX_W]);
        w_wr_in_range = (w_cap_addr[ADDR_WIDTH-1:IDX_W] == BASE_A[ADDR_WIDTH-1:IDX_W]);
        // On an access edge the only possible error is an unstable transfer.
        w_wr_ok       = w_access_edge & ~w_err & w_cap_write & w_wr_in_range;

        // STATUS: clear (W1C) first, then set, so a same-edge set wins.
        w_stat_next = '0;
        w_stat_next[STAT_PERR_BIT] =
            (r_regs[STAT_IDX][STAT_PERR_BIT] &
             ~(w_wr_ok && (w_wr_idx == STAT_IDX) && w_cap_wdata[STAT_PERR_BIT])) |
            w_err;
        w_stat_next[STAT_OOR_BIT] =
            (r_regs[STAT_IDX][STAT_OOR_BIT] &
             ~(w_wr_ok && (w_wr_idx == STAT_IDX) && w_cap_wdata[STAT_OOR_BIT])) |
            (w_access_edge & ~w_wr_in_range);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_prdata    <= '0;
            r_wr_strobe <= '0;
            r_prot_err  <= 1'b0;
        end else begin
            r_wr_strobe <= '0;
            r_prot_err  <= w_err;
            if (w_setup_edge) begin
                r_prdata <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
            end
            if (w_wr_ok) begin
                if (w_wr_idx < WCNT_IDX) begin
                    r_regs[w_wr_idx] <= w_cap_wdata;
                end
                r_wr_strobe[w_wr_idx] <= 1'b1;
                r_regs[WCNT_IDX]      <= r_regs[WCNT_IDX] + 1'b1;
            end
            r_regs[STAT_IDX] <= w_stat_next;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign prdata    = r_prdata;
    assign wr_strobe = r_wr_strobe;
    assign prot_err  = r_prot_err;

endmodule
